// File: rtl/serial_word_deframer.sv
// serial_word_deframer
// Assembles an MSB-first serial bit stream into W-bit words. Each word-boundary
// tick pushes the word into a DEPTH-entry FIFO that is read through a
// valid/ready handshake. A word that finds the FIFO full is dropped and the
// sticky overflow flag is raised.
// Optional build macro DEFRAMER_BITCHECK_EN adds a shift counter that raises
// the sticky frame_err flag when a tick closes a word that does not have
// exactly W bits. Without the macro, o_frame_err is tied low.
module serial_word_deframer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_shift,
  input  logic                     i_sdata,
  input  logic                     i_tick,
  output logic [W-1:0]             o_m_data,
  output logic                     o_m_valid,
  input  logic                     i_m_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [W-1:0]  r_sr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [W-1:0]  w_word;
  logic          w_pop;
  logic          w_full;
  logic          w_push;

  // A bit shifted in on the tick cycle still belongs to the word being closed.
  assign w_word = i_shift ? {r_sr[W-2:0], i_sdata} : r_sr;
  // Popping only happens when there is a head word; clear overrides pops
  // and pushes inside the sequential blocks.
  assign w_pop  = (r_count != '0) && i_m_ready;
  assign w_full = (r_count == FULL_C);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push = i_tick && (!w_full || w_pop);

  assign o_m_valid  = (r_count != '0);
  // The empty FIFO presents zero so stale entries never leak out.
  assign o_m_data   = o_m_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Serial shift register; not cleared by tick so repeated ticks re-push it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= {r_sr[W-2:0], i_sdata};
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (!i_clear && w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (i_tick && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef DEFRAMER_BITCHECK_EN
  localparam int BW = $clog2(W + 2);
  localparam logic [BW-1:0] BC_SAT = BW'(W + 1);
  localparam logic [BW-1:0] BC_W   = BW'(W);

  logic [BW-1:0] r_bc;
  logic [BW-1:0] w_n;
  logic          r_frame_err;

  // Shifts seen so far including this cycle's, saturating at W+1.
  assign w_n = (i_shift && (r_bc != BC_SAT)) ? r_bc + 1'b1 : r_bc;

  // Bit counter restarts on each tick; a word of the wrong length sets frame_err.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bc        <= '0;
      r_frame_err <= 1'b0;
    end else if (i_clear) begin
      r_bc        <= '0;
      r_frame_err <= 1'b0;
    end else if (i_tick) begin
      r_bc <= '0;
      if (w_n != BC_W) begin
        r_frame_err <= 1'b1;
      end
    end else begin
      r_bc <= w_n;
    end
  end

  assign o_frame_err = r_frame_err;
`else
  assign o_frame_err = 1'b0;
`endif

endmodule
